// File: rtl/uart_tx_ctrl.sv
`default_nettype none
// ============================================================================
// Module      : uart_tx_ctrl
// Description : UART transmit framing controller. Sends one serial bit per
//               clk: start bit, DATAWIDTH data bits LSB first, optional
//               parity bit (from an external parity calculator), stop bit.
//               Every line-facing output is a flip-flop.
// Revision    : 1.0 - initial release
// ============================================================================
module uart_tx_ctrl #(
    parameter int DATAWIDTH = 8
) (
    input  logic                 clk,
    input  logic                 rst,
    input  logic [DATAWIDTH-1:0] P_DATA,
    input  logic                 Data_Valid,
    input  logic                 PAR_EN,
    input  logic                 PAR_TYP,
    input  logic                 par_bit,
    output logic                 par_load,
    output logic                 par_type,
    output logic                 TX_OUT,
    output logic                 busy,
    output logic                 frame_done
);

    localparam int c_CW = (DATAWIDTH > 1) ? $clog2(DATAWIDTH) : 1;
    localparam logic [c_CW-1:0] c_LAST = c_CW'(DATAWIDTH - 1);

    localparam logic [2:0] c_IDLE   = 3'd0;
    localparam logic [2:0] c_START  = 3'd1;
    localparam logic [2:0] c_DATA   = 3'd2;
    localparam logic [2:0] c_PARITY = 3'd3;
    localparam logic [2:0] c_STOP   = 3'd4;

    logic [2:0]           r_state;
    logic [DATAWIDTH-1:0] r_shift;
    logic [c_CW-1:0]      r_cnt;
    logic                 r_par_en;
    logic                 r_par_type;
    logic                 r_tx;
    logic                 r_busy;
    logic                 r_frame_done;
    logic                 w_accept;

    // Accept strobe: idle controller seeing a request, never while in reset.
    assign w_accept   = (r_state == c_IDLE) && Data_Valid && !rst;
    assign par_load   = w_accept;
    assign par_type   = r_par_type;
    assign TX_OUT     = r_tx;
    assign busy       = r_busy;
    assign frame_done = r_frame_done;

    // Frame sequencer. Line outputs are loaded with the value belonging to the
    // state being entered, so they appear in the same cycle as that state.
    always_ff @(posedge clk) begin
        if (rst) begin
            r_state      <= c_IDLE;
            r_shift      <= '0;
            r_cnt        <= '0;
            r_par_en     <= 1'b0;
            r_par_type   <= 1'b0;
            r_tx         <= 1'b1;
            r_busy       <= 1'b0;
            r_frame_done <= 1'b0;
        end else begin
            case (r_state)
                c_IDLE: begin
                    r_tx         <= 1'b1;
                    r_busy       <= 1'b0;
                    r_frame_done <= 1'b0;
                    if (Data_Valid) begin
                        r_shift    <= P_DATA;
                        r_par_en   <= PAR_EN;
                        r_par_type <= PAR_TYP;
                        r_state    <= c_START;
                        r_tx       <= 1'b0;
                        r_busy     <= 1'b1;
                    end
                end
                c_START: begin
                    r_tx    <= r_shift[0];
                    r_shift <= r_shift >> 1;
                    r_cnt   <= '0;
                    r_state <= c_DATA;
                end
                c_DATA: begin
                    if (r_cnt == c_LAST) begin
                        r_cnt <= '0;
                        if (r_par_en) begin
                            // The parity calculator was loaded at accept, so
                            // its result is settled by now; capturing it on
                            // the edge into PARITY puts it on the line for
                            // exactly the PARITY cycle.
                            r_state <= c_PARITY;
                            r_tx    <= par_bit;
                        end else begin
                            r_state      <= c_STOP;
                            r_tx         <= 1'b1;
                            r_frame_done <= 1'b1;
                        end
                    end else begin
                        r_cnt   <= r_cnt + 1'b1;
                        r_tx    <= r_shift[0];
                        r_shift <= r_shift >> 1;
                    end
                end
                c_PARITY: begin
                    r_state      <= c_STOP;
                    r_tx         <= 1'b1;
                    r_frame_done <= 1'b1;
                end
                c_STOP: begin
                    r_state      <= c_IDLE;
                    r_tx         <= 1'b1;
                    r_busy       <= 1'b0;
                    r_frame_done <= 1'b0;
                end
                default: begin
                    r_state      <= c_IDLE;
                    r_cnt        <= '0;
                    r_tx         <= 1'b1;
                    r_busy       <= 1'b0;
                    r_frame_done <= 1'b0;
                end
            endcase
        end
    end

endmodule
`default_nettype wire

// File: doc/uart_tx_ctrl.md
UART_TX_CTRL -- requirements
Module: uart_tx_ctrl

Interface
REQ-001 Parameter: DATAWIDTH, default 8, number of data bits per frame (>=2).
REQ-002 clk  input  1  baud-rate clock; one serial bit per clk cycle; all state updates on rising edge.
REQ-003 rst  input  1  reset, synchronous, active-high.
REQ-004 P_DATA  input  DATAWIDTH  parallel byte to transmit; sampled only on accept.
REQ-005 Data_Valid  input  1  transmit request; accepted only when state is IDLE.
REQ-006 PAR_EN  input  1  1 = frame includes parity bit; sampled on accept.
REQ-007 PAR_TYP  input  1  0 = even, 1 = odd; sampled on accept.
REQ-008 par_bit  input  1  parity result from the parity calculator; sampled in PARITY state only.
REQ-009 par_load  output  1  combinational accept strobe to the parity calculator's data-valid input; high for exactly the accept cycle.
REQ-010 par_type  output  1  registered copy of PAR_TYP captured on accept; drives the parity calculator's type input.
REQ-011 TX_OUT  output  1  serial line; driven directly by a flip-flop.
REQ-012 busy  output  1  registered; high while a frame is on the line.
REQ-013 frame_done  output  1  registered; one-cycle pulse in the STOP bit cycle.

Function
REQ-014 States SHALL be IDLE, START, DATA, PARITY, STOP.
REQ-015 Accept SHALL occur in any cycle with state==IDLE and Data_Valid==1: latch P_DATA into shift register, latch PAR_EN, latch PAR_TYP to par_type, assert par_load, next state START.
REQ-016 Data_Valid in any non-IDLE state SHALL be ignored: no latching, par_load low.
REQ-017 For accept at cycle N, TX_OUT SHALL be 0 (start bit) in cycle N+1.
REQ-018 DATA SHALL last exactly DATAWIDTH cycles (N+2 .. N+1+DATAWIDTH), LSB first; bit counter counts 0..DATAWIDTH-1 and clears on leaving DATA.
REQ-019 If latched PAR_EN==1: PARITY in cycle N+2+DATAWIDTH, TX_OUT = par_bit; then STOP in N+3+DATAWIDTH.
REQ-020 If latched PAR_EN==0: PARITY skipped; STOP in N+2+DATAWIDTH.
REQ-021 STOP SHALL drive TX_OUT=1 for one cycle, pulse frame_done, then go to IDLE.
REQ-022 busy SHALL be high from the START cycle through the STOP cycle inclusive; low in IDLE.
REQ-023 In IDLE, TX_OUT SHALL be 1.
REQ-024 With Data_Valid held high continuously, frames SHALL run back-to-back with exactly one IDLE cycle (TX_OUT=1) between STOP and next START.
REQ-025 Changes on PAR_EN, PAR_TYP, P_DATA after accept SHALL NOT affect the frame in progress.

Reset
REQ-026 rst high at a clock edge SHALL force: state IDLE, TX_OUT=1, busy=0, frame_done=0, par_type=0, shift register=0, bit counter=0; rst has priority over Data_Valid.
REQ-027 par_load SHALL be 0 in any cycle where rst is high.
REQ-028 Reset mid-frame SHALL abort the frame immediately; no frame_done pulse; next accept is possible in the first cycle after rst deasserts.

Verification
REQ-029 P_DATA=0xA5, PAR_EN=1, PAR_TYP=0, accept at N, parity calculator connected -> TX_OUT from N+1: 0,1,0,1,0,0,1,0,1,0,1; busy high N+1..N+11; frame_done at N+11.
REQ-030 P_DATA=0x00, PAR_EN=0 -> TX_OUT: 0, eight 0s, 1; busy high 10 cycles; no PARITY state visited.
REQ-031 P_DATA=0x01, PAR_EN=1, PAR_TYP=1, PAR_TYP toggled every cycle after accept -> par_type stays 1; parity bit on line = 0.
REQ-032 Data_Valid held high with P_DATA=0x55, PAR_EN=0 -> period 11 cycles; one TX_OUT=1 idle cycle between consecutive STOP and START; par_load pulses once per frame.
REQ-033 Data_Valid pulse with P_DATA=0x3C at N+4 during a 0xA5 frame -> ignored; 0xA5 frame bit-exact; par_load low.
REQ-034 rst pulse during DATA bit 3 -> next cycle TX_OUT=1, busy=0, no frame_done; a following 0xA5 accept produces the bit-exact sequence from REQ-029.
